// File: rtl/pt8211_rx.sv
// PT8211-format stereo serial receiver: oversamples BCK/WS/DIN in the clk domain,
// deserializes left/right words and hands out complete pairs on a valid/ready port.
module pt8211_rx #(
  parameter int DATA_W      = 16,
  parameter int SLOT_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              HP_BCK,
  input  logic              HP_WS,
  input  logic              HP_DIN,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              locked,
  output logic              frame_err,
  output logic              overrun
);

  localparam int              CNT_W    = $clog2(2 * SLOT_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(2 * SLOT_W - 1);
  localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_W);

  typedef enum logic {ALIGN, TRACK} align_t;
  align_t align_state;

  logic [SYNC_STAGES-1:0] bck_sync, ws_sync, din_sync;
  logic                   bck_d, en_q, bit_q, ws_q, ws_prev, left_ok;
  logic [DATA_W-1:0]      sr, left_hold;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   fall, boundary, word_good, checked, closes_left, closes_right, pair_form;

  always_comb begin
    fall         = bck_d & ~bck_sync[SYNC_STAGES-1];
    boundary     = en_q & (ws_q != ws_prev);
    word_good    = (bit_cnt == CNT_SLOT);
    checked      = boundary & (align_state == TRACK);
    closes_left  = checked & word_good & ~ws_prev;
    closes_right = checked & word_good & ws_prev;
    pair_form    = closes_right & left_ok;
  end

  // The sample enable is registered once more so the pair lands SYNC_STAGES+2 clocks after the pin edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bck_sync    <= '0;
      ws_sync     <= '0;
      din_sync    <= '0;
      bck_d       <= 1'b0;
      en_q        <= 1'b0;
      bit_q       <= 1'b0;
      ws_q        <= 1'b0;
      ws_prev     <= 1'b0;
      left_ok     <= 1'b0;
      sr          <= '0;
      left_hold   <= '0;
      bit_cnt     <= '0;
      align_state <= ALIGN;
      left_data   <= '0;
      right_data  <= '0;
      out_valid   <= 1'b0;
      locked      <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      bck_sync  <= {bck_sync[SYNC_STAGES-2:0], HP_BCK};
      ws_sync   <= {ws_sync[SYNC_STAGES-2:0], HP_WS};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], HP_DIN};
      bck_d     <= bck_sync[SYNC_STAGES-1];
      en_q      <= fall;
      bit_q     <= din_sync[SYNC_STAGES-1];
      ws_q      <= ws_sync[SYNC_STAGES-1];
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      if (en_q) begin
        if (boundary) begin
          sr      <= DATA_W'(bit_q);
          bit_cnt <= CNT_W'(1);
          ws_prev <= ws_q;
          if (align_state == ALIGN) begin
            align_state <= TRACK;
          end else if (word_good) begin
            locked <= 1'b1;
            if (closes_left) begin
              left_hold <= sr;
              left_ok   <= 1'b1;
            end else begin
              left_ok   <= 1'b0;
            end
          end else begin
            frame_err <= 1'b1;
            locked    <= 1'b0;
            left_ok   <= 1'b0;
          end
        end else begin
          sr <= {sr[DATA_W-2:0], bit_q};
          if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
        end
      end

      if (pair_form) begin
        if (!out_valid || out_ready) begin
          left_data  <= left_hold;
          right_data <= sr;
          out_valid  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
